vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster position (x, y) and the VGA sync/blank strobes that drive the team's video generator and the ADV7123-style DAC.
- Runs from the 50 MHz board clock. An internal divider creates a 25 MHz pixel enable and the DAC pixel clock.
- Implements 640x480@60 timing: 800 pixels x 525 lines.
- All counts are parameterised so other modes can be built from the same block.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- CLK_DIV, 2, clk cycles per pixel; even and >=2

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous active-high reset
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_b  out  1  high while (x,y) is inside the visible area
- sync_b  out  1  composite sync to DAC; constant 0
- vgaclk  out  1  pixel clock to DAC, period CLK_DIV clk cycles
- pix_tick  out  1  one-clk pulse on the cycle x/y advance
- line_start  out  1  one-clk pulse when x becomes 0
- frame_start  out  1  one-clk pulse when (x,y) becomes (0,0)

Behaviour:
- Fixed interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- All outputs are registered. Reset values represent position (0,0):
  - x=0, y=0, hsync=1, vsync=1, blank_b=1
  - vgaclk=0, pix_tick=0, line_start=0, frame_start=0
  - divider count=0
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick is 1 on the clk edge where div_cnt goes CLK_DIV-1 -> 0.
  - vgaclk = (div_cnt >= CLK_DIV/2), registered. x/y therefore change on the vgaclk falling edge, and the DAC samples mid-pixel on the rising edge.
- Horizontal phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE. It advances only on a pixel tick.
  - x < H_ACTIVE: ACTIVE
  - H_ACTIVE..H_ACTIVE+H_FP-1: FRONT
  - next H_SYNC counts: SYNC
  - remainder: BACK
  - x wraps H_TOTAL-1 -> 0.
- Vertical phase FSM: same four states over y, with V_* parameters. It advances only on a tick where x wraps. y wraps V_TOTAL-1 -> 0 on the tick where x also wraps.
- Decodes are computed from the next count and registered on the same edge as the count, so they are always aligned with x/y (zero latency):
  - hsync = 0 iff horizontal phase is SYNC (x in 656..751 by default)
  - vsync = 0 iff vertical phase is SYNC (y in 490..491)
  - blank_b = 1 iff both phases are ACTIVE
- Pulses:
  - line_start = 1 for exactly one clk, coincident with the edge that loads x=0.
  - frame_start = 1 for exactly one clk, coincident with the edge that loads x=0 and y=0; line_start is also 1 on that cycle.
- Widths: x and y are 10-bit unsigned. The design must elaborate-time assert H_TOTAL<=1024, V_TOTAL<=1024 and CLK_DIV even.
- Reset mid-frame: all outputs return to their reset values immediately, asynchronously. After reset release, the first pix_tick occurs CLK_DIV clk edges later and moves the position to (1,0).
- The vertical count never changes except on an x wrap; a y change without an x wrap is illegal.

Decomposition:
- Package vga_pkg holds:
  - the 640x480 timing localparams and derived H_TOTAL/V_TOTAL
  - typedef enum vga_phase_t {ACTIVE, FRONT, SYNC, BACK}
  - the 10-bit coord_t typedef
- Sub-module vga_axis_counter(ACTIVE, FP, SYNC, BP): counter plus phase FSM with inputs en and rst, outputs count, phase and wrap.
  - Instantiated twice: horizontal with en=pix_tick; vertical with en=pix_tick & h_wrap.

Test Plan:
- Reset release → hold rst 3 cycles then release: outputs stay at reset values; first pix_tick at clk edge 2 after release; x=1, y=0; vgaclk toggles every clk.
- Horizontal timing → run one line: hsync falls when x=656, rises when x=752; blank_b falls at x=640; line_start pulses every 1600 clk.
- Vertical timing → run one frame: vsync low exactly for y=490..491 (1600 pixels); blank_b=0 for all y>=480; frame_start period is 840000 clk.
- Wrap → at x=799, y=524 the next tick gives x=0, y=0, frame_start=1, line_start=1, blank_b=1, hsync=1, vsync=1.
- Async reset mid-frame → assert rst at x=300, y=200 between clk edges: outputs reset before the next edge; counting restarts from (0,0).
- Parameter override → H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_* = 4/1/1/1, CLK_DIV=4: line length 14 ticks; hsync low for x=10..11; pix_tick every 4 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
// Contents: coord_t (10-bit raster coordinate), vga_phase_t (per-axis phase),
// default per-axis timing counts and their derived totals.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_CLK_DIV  = 2;

   localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   typedef logic [9:0] coord_t;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } vga_phase_t;

   function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/sync bundle between the timing generator and its consumers
// (video generator, DAC).
//   x, y        : raster position
//   hsync/vsync : active-low syncs
//   blank_b     : high inside the visible area
//   sync_b      : DAC composite sync (held low)
//   vgaclk      : DAC pixel clock
//   pix_tick    : one-clk pulse when x/y advance
//   line_start  : one-clk pulse when x becomes 0
//   frame_start : one-clk pulse when (x,y) becomes (0,0)
// master = timing generator, slave = consumer.
interface vga_timing_gen_if;
   import vga_pkg::*;

   coord_t x;
   coord_t y;
   logic   hsync;
   logic   vsync;
   logic   blank_b;
   logic   sync_b;
   logic   vgaclk;
   logic   pix_tick;
   logic   line_start;
   logic   frame_start;

   modport master (
      output x, y, hsync, vsync, blank_b, sync_b, vgaclk, pix_tick, line_start, frame_start
   );

   modport slave (
      input x, y, hsync, vsync, blank_b, sync_b, vgaclk, pix_tick, line_start, frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus phase FSM.
// Ports: clk, rst (async, active-high), en (advance one count),
//        count (registered position), phase_nxt (phase the axis holds after
//        the current edge, for zero-latency registered decodes upstream),
//        wrap (count is at its last value; the next en returns it to 0).
//
// state  | meaning
// ACTIVE | count in 0 .. ACTIVE_LEN-1 (visible)
// FRONT  | front porch
// SYNC   | sync pulse
// BACK   | back porch, ends at TOTAL-1
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE_LEN = VGA_H_ACTIVE,
   parameter int FP_LEN     = VGA_H_FP,
   parameter int SYNC_LEN   = VGA_H_SYNC,
   parameter int BP_LEN     = VGA_H_BP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output coord_t     count,
   output vga_phase_t phase_nxt,
   output logic       wrap
);

   localparam int     TOTAL      = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
   localparam coord_t LAST       = coord_t'(TOTAL - 1);
   localparam coord_t FP_START   = coord_t'(ACTIVE_LEN);
   localparam coord_t SYNC_START = coord_t'(ACTIVE_LEN + FP_LEN);
   localparam coord_t BP_START   = coord_t'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

   coord_t     count_q, count_d;
   vga_phase_t phase_q, phase_d;

   // Transitions look at the next count so the phase register lands on the
   // same edge as the count it describes.
   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      if (en) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
         case (phase_q)
            ACTIVE:  if (count_d == FP_START)   phase_d = FRONT;
            FRONT:   if (count_d == SYNC_START) phase_d = SYNC;
            SYNC:    if (count_d == BP_START)   phase_d = BACK;
            BACK:    if (count_d == '0)         phase_d = ACTIVE;
            default: phase_d = ACTIVE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         phase_q <= ACTIVE;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   assign count     = count_q;
   assign phase_nxt = phase_d;
   assign wrap      = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters with phase FSMs, and registered sync/blank/strobe outputs.
// Ports: clk (system clock), rst (async, active-high),
//        vga (master side of vga_timing_gen_if: x, y, hsync, vsync, blank_b,
//        sync_b, vgaclk, pix_tick, line_start, frame_start).
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int CLK_DIV  = VGA_CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   if (H_TOTAL > 1024) begin : g_chk_h
      $error("H_TOTAL does not fit a 10-bit coordinate");
   end
   if (V_TOTAL > 1024) begin : g_chk_v
      $error("V_TOTAL does not fit a 10-bit coordinate");
   end
   if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_chk_div
      $error("CLK_DIV must be even and at least 2");
   end

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             tick;
   logic             h_wrap, v_wrap;
   coord_t           h_count, v_count;
   vga_phase_t       h_phase_nxt, v_phase_nxt;

   logic vgaclk_q, vgaclk_d;
   logic pix_tick_q, pix_tick_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;
   logic hsync_q, hsync_d;
   logic vsync_q, vsync_d;
   logic blank_b_q, blank_b_d;

   assign tick = (div_cnt_q == DIV_LAST);

   vga_axis_counter #(
      .ACTIVE_LEN (H_ACTIVE),
      .FP_LEN     (H_FP),
      .SYNC_LEN   (H_SYNC),
      .BP_LEN     (H_BP)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .en        (tick),
      .count     (h_count),
      .phase_nxt (h_phase_nxt),
      .wrap      (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE_LEN (V_ACTIVE),
      .FP_LEN     (V_FP),
      .SYNC_LEN   (V_SYNC),
      .BP_LEN     (V_BP)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .en        (tick & h_wrap),
      .count     (v_count),
      .phase_nxt (v_phase_nxt),
      .wrap      (v_wrap)
   );

   // vgaclk falls on the tick edge, so the DAC's rising edge lands mid-pixel.
   always_comb begin
      div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
      vgaclk_d      = (div_cnt_d >= DIV_HALF);
      pix_tick_d    = tick;
      line_start_d  = tick & h_wrap;
      frame_start_d = tick & h_wrap & v_wrap;
      hsync_d       = (h_phase_nxt != SYNC);
      vsync_d       = (v_phase_nxt != SYNC);
      blank_b_d     = (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q     <= '0;
         vgaclk_q      <= 1'b0;
         pix_tick_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_b_q     <= 1'b1;
      end else begin
         div_cnt_q     <= div_cnt_d;
         vgaclk_q      <= vgaclk_d;
         pix_tick_q    <= pix_tick_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_b_q     <= blank_b_d;
      end
   end

   // The line counter may only move on a tick that also wraps x.
   a_v_moves_on_wrap : assert property (@(posedge clk) disable iff (rst)
      (v_count != $past(v_count)) |-> $past(tick & h_wrap));

   assign vga.x           = h_count;
   assign vga.y           = v_count;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.blank_b     = blank_b_q;
   assign vga.sync_b      = 1'b0;
   assign vga.vgaclk      = vgaclk_q;
   assign vga.pix_tick    = pix_tick_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a
// small-mode instance (14x7 raster, CLK_DIV=4) run side by side.
module tb_vga_timing_gen;

   logic clk;
   logic rst_d;
   logic rst_s;

   vga_timing_gen_if vga_d ();
   vga_timing_gen_if vga_s ();

   vga_timing_gen dut_d (
      .clk (clk),
      .rst (rst_d),
      .vga (vga_d)
   );

   vga_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .CLK_DIV  (4)
   ) dut_s (
      .clk (clk),
      .rst (rst_s),
      .vga (vga_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x, y, hs, vs, bl, vc, pt, ls, fs;
   } obs_t;

   typedef struct {
      int   n;      // clk edges since reset release
      bit   sel;    // 0: default instance, 1: small instance
      obs_t e;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   n_edge = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic obs_t observe(input bit sel);
      obs_t o;
      if (!sel) begin
         o.x = int'(vga_d.x); o.y = int'(vga_d.y);
         o.hs = int'(vga_d.hsync); o.vs = int'(vga_d.vsync); o.bl = int'(vga_d.blank_b);
         o.vc = int'(vga_d.vgaclk); o.pt = int'(vga_d.pix_tick);
         o.ls = int'(vga_d.line_start); o.fs = int'(vga_d.frame_start);
      end else begin
         o.x = int'(vga_s.x); o.y = int'(vga_s.y);
         o.hs = int'(vga_s.hsync); o.vs = int'(vga_s.vsync); o.bl = int'(vga_s.blank_b);
         o.vc = int'(vga_s.vgaclk); o.pt = int'(vga_s.pix_tick);
         o.ls = int'(vga_s.line_start); o.fs = int'(vga_s.frame_start);
      end
      return o;
   endfunction

   task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
      chk({tag, " x"}, a.x, e.x);
      chk({tag, " y"}, a.y, e.y);
      chk({tag, " hsync"}, a.hs, e.hs);
      chk({tag, " vsync"}, a.vs, e.vs);
      chk({tag, " blank_b"}, a.bl, e.bl);
      chk({tag, " vgaclk"}, a.vc, e.vc);
      chk({tag, " pix_tick"}, a.pt, e.pt);
      chk({tag, " line_start"}, a.ls, e.ls);
      chk({tag, " frame_start"}, a.fs, e.fs);
   endtask

   task automatic add(input int n, input bit sel, input int x, input int y, input int hs,
                      input int vs, input int bl, input int vc, input int pt, input int ls,
                      input int fs);
      vec_t v;
      v.n = n; v.sel = sel;
      v.e.x = x; v.e.y = y; v.e.hs = hs; v.e.vs = vs; v.e.bl = bl;
      v.e.vc = vc; v.e.pt = pt; v.e.ls = ls; v.e.fs = fs;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n_edge++;
   endtask

   function automatic int sig(input bit sel, input int which);
      obs_t o;
      o = observe(sel);
      case (which)
         0:       return o.pt;
         1:       return o.ls;
         default: return o.fs;
      endcase
   endfunction

   // Edges between two consecutive pulses of a strobe; -1 if not seen in budget.
   task automatic meas(input bit sel, input int which, input int budget, output int period);
      int first;
      first  = -1;
      period = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (sig(sel, which) == 1) begin
            if (first < 0) first = n_edge;
            else begin
               period = n_edge - first;
               break;
            end
         end
      end
   endtask

   obs_t reset_obs;
   obs_t o;
   int   per;
   int   cnt_hs, cnt_vs, cnt_bl, cnt_pt;
   bit   found;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_obs = '{x:0, y:0, hs:1, vs:1, bl:1, vc:0, pt:0, ls:0, fs:0};

      //      n     sel x    y  hs vs bl vc pt ls fs
      add(   0, 0,   0,   0, 1, 1, 1, 0, 0, 0, 0);
      add(   0, 1,   0,   0, 1, 1, 1, 0, 0, 0, 0);
      add(   1, 0,   0,   0, 1, 1, 1, 1, 0, 0, 0);
      add(   2, 0,   1,   0, 1, 1, 1, 0, 1, 0, 0);
      add(   3, 0,   1,   0, 1, 1, 1, 1, 0, 0, 0);
      add(   4, 1,   1,   0, 1, 1, 1, 0, 1, 0, 0);
      add(   6, 1,   1,   0, 1, 1, 1, 1, 0, 0, 0);
      add(  40, 1,  10,   0, 0, 1, 0, 0, 1, 0, 0);
      add(  44, 1,  11,   0, 0, 1, 0, 0, 1, 0, 0);
      add(  48, 1,  12,   0, 1, 1, 0, 0, 1, 0, 0);
      add(  52, 1,  13,   0, 1, 1, 0, 0, 1, 0, 0);
      add(  56, 1,   0,   1, 1, 1, 1, 0, 1, 1, 0);
      add( 224, 1,   0,   4, 1, 1, 0, 0, 1, 1, 0);
      add( 280, 1,   0,   5, 1, 0, 0, 0, 1, 1, 0);
      add( 284, 1,   1,   5, 1, 0, 0, 0, 1, 0, 0);
      add( 336, 1,   0,   6, 1, 1, 0, 0, 1, 1, 0);
      add( 388, 1,  13,   6, 1, 1, 0, 0, 1, 0, 0);
      add( 392, 1,   0,   0, 1, 1, 1, 0, 1, 1, 1);
      add( 393, 1,   0,   0, 1, 1, 1, 0, 0, 0, 0);
      add(1278, 0, 639,   0, 1, 1, 1, 0, 1, 0, 0);
      add(1280, 0, 640,   0, 1, 1, 0, 0, 1, 0, 0);
      add(1310, 0, 655,   0, 1, 1, 0, 0, 1, 0, 0);
      add(1312, 0, 656,   0, 0, 1, 0, 0, 1, 0, 0);
      add(1503, 0, 751,   0, 0, 1, 0, 1, 0, 0, 0);
      add(1504, 0, 752,   0, 1, 1, 0, 0, 1, 0, 0);
      add(1598, 0, 799,   0, 1, 1, 0, 0, 1, 0, 0);
      add(1600, 0,   0,   1, 1, 1, 1, 0, 1, 1, 0);
      add(1601, 0,   0,   1, 1, 1, 1, 1, 0, 0, 0);
      add(3200, 0,   0,   2, 1, 1, 1, 0, 1, 1, 0);
      add(3202, 0,   1,   2, 1, 1, 1, 0, 1, 0, 0);

      // Reset held with the clock running: outputs stay at reset values.
      rst_d = 1'b1;
      rst_s = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_obs($sformatf("rst_hold%0d dflt", i), observe(0), reset_obs);
         chk($sformatf("rst_hold%0d small x", i), int'(vga_s.x), 0);
      end
      chk("sync_b", int'(vga_d.sync_b), 0);

      @(negedge clk);
      rst_d  = 1'b0;
      rst_s  = 1'b0;
      n_edge = 0;
      #1;

      foreach (vecs[k]) begin
         while (n_edge < vecs[k].n) step();
         chk_obs($sformatf("vec%0d n=%0d sel=%0d", k, vecs[k].n, vecs[k].sel),
                 observe(vecs[k].sel), vecs[k].e);
      end

      // Line period and pixel rate on the default instance.
      meas(0, 1, 4000, per);
      chk("dflt line_start period", per, 1600);
      cnt_pt = 0;
      for (int i = 0; i < 1600; i++) begin
         step();
         cnt_pt += int'(vga_d.pix_tick);
      end
      chk("dflt pix_tick per line", cnt_pt, 800);
      chk("sync_b running", int'(vga_d.sync_b), 0);

      // Small instance: strobe periods and per-frame sync/blank totals.
      meas(1, 0, 20, per);
      chk("small pix_tick period", per, 4);
      meas(1, 1, 200, per);
      chk("small line_start period", per, 56);
      meas(1, 2, 1000, per);
      chk("small frame_start period", per, 392);
      cnt_hs = 0; cnt_vs = 0; cnt_bl = 0;
      for (int i = 0; i < 392; i++) begin
         step();
         cnt_hs += (vga_s.hsync == 1'b0) ? 1 : 0;
         cnt_vs += (vga_s.vsync == 1'b0) ? 1 : 0;
         cnt_bl += int'(vga_s.blank_b);
      end
      chk("small hsync low clk/frame", cnt_hs, 56);
      chk("small vsync low clk/frame", cnt_vs, 56);
      chk("small blank_b high clk/frame", cnt_bl, 128);

      // Asynchronous reset mid-frame on the default instance.
      found = 1'b0;
      for (int i = 0; i < 3300; i++) begin
         step();
         if (vga_d.x == 10'd300 && vga_d.y != 10'd0) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach x=300 mid-frame", int'(found), 1);
      @(negedge clk);
      rst_d = 1'b1;
      #1;
      chk_obs("async rst before edge", observe(0), reset_obs);
      step();
      chk_obs("async rst held", observe(0), reset_obs);
      o = observe(1);
      chk("small unaffected by dflt rst", int'(o.x != 0 || o.y != 0 || o.pt != 0 || o.vc != 0), 1);
      @(negedge clk);
      rst_d = 1'b0;
      #1;
      step();
      chk_obs("post rst edge1", observe(0), '{x:0, y:0, hs:1, vs:1, bl:1, vc:1, pt:0, ls:0, fs:0});
      step();
      chk_obs("post rst edge2", observe(0), '{x:1, y:0, hs:1, vs:1, bl:1, vc:0, pt:1, ls:0, fs:0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
